operand_fetch_sequencer: RTL and testbench
==========================================

OPERAND_FETCH_SEQUENCER -- requirements
Module: operand_fetch_sequencer

Interface
REQ-001 The block SHALL have parameter BufferDepth, default 2, meaning the entry count of the downstream operand queue, which is also the maximum credits.
REQ-002 The block SHALL have parameter AddrWidth, default 10, meaning the VRF word-address width.
REQ-003 The block SHALL have parameter LenWidth, default 16, meaning the width of the 64-bit word count.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_valid_i / req_ready_o, input / output, 1 bit each: fetch-command handshake.
REQ-007 The block SHALL have port req_addr_i, input, AddrWidth bits: first VRF word address.
REQ-008 The block SHALL have port req_len_i, input, LenWidth bits: number of 64-bit words to fetch.
REQ-009 The block SHALL have port req_conv_i, input, 4 bits: operand conversion code forwarded to the queue.
REQ-010 The block SHALL have port kill_i, input, 1 bit: abort the command in flight.
REQ-011 The block SHALL have port vrf_req_o, output, 1 bit: VRF read request.
REQ-012 The block SHALL have port vrf_addr_o, output, AddrWidth bits: VRF read address.
REQ-013 The block SHALL have port vrf_gnt_i, input, 1 bit: bank-arbiter grant.
REQ-014 The block SHALL have port operand_issued_o, output, 1 bit: a read was granted (to the queue's issued input).
REQ-015 The block SHALL have port operand_consumed_i, input, 1 bit: the queue popped one element (credit return).
REQ-016 The block SHALL have port queue_cmd_valid_o, output, 1 bit: single-cycle queue command strobe.
REQ-017 The block SHALL have port queue_cmd_conv_o, output, 4 bits: conversion code of the strobed command.
REQ-018 The block SHALL have port queue_cmd_len_o, output, LenWidth bits: word count of the strobed command.
REQ-019 The block SHALL have port busy_o, output, 1 bit: the FSM is not IDLE.
REQ-020 The block SHALL have port credit_err_o, output, 1 bit: sticky flag for a credit return while credits were full.

Function
REQ-021 The FSM SHALL have two states, IDLE and ISSUE; req_ready_o SHALL be 1 only in IDLE.
REQ-022 On a req_valid_i && req_ready_o handshake with req_len_i>0, the block SHALL latch addr, len and conv and enter ISSUE next cycle; in that same next cycle it SHALL pulse queue_cmd_valid_o for exactly one cycle with the latched conv and len.
REQ-023 On a handshake with req_len_i==0, the block SHALL emit no command strobe and no VRF request, and SHALL stay in IDLE.
REQ-024 In ISSUE, vrf_req_o SHALL equal (credits>0) && (remaining>0) && !kill_i, combinationally.
REQ-025 vrf_addr_o SHALL be the current latched address.
REQ-026 When vrf_req_o && vrf_gnt_i, the block SHALL pulse operand_issued_o that cycle, decrement credits, increment the address modulo 2^AddrWidth (wrapping to 0), and decrement remaining.
REQ-027 When the last word is granted (remaining==1), the block SHALL return to IDLE next cycle; back-to-back commands SHALL therefore have a one-cycle IDLE gap.
REQ-028 The credit counter SHALL range 0..BufferDepth, and grant and consume in the same cycle SHALL leave it unchanged.
REQ-029 A consume with no grant SHALL increment credits; if credits==BufferDepth, the counter SHALL saturate and set credit_err_o until reset.
REQ-030 Credits SHALL be independent of commands: a new command SHALL start with whatever credits remain, since the queue may still hold words from the previous command.
REQ-031 kill_i in ISSUE SHALL suppress vrf_req_o that cycle and force IDLE next cycle, discarding remaining; credits SHALL NOT be restored, because already-issued operands still arrive and are returned via operand_consumed_i.
REQ-032 kill_i in IDLE SHALL have no effect, and a handshake in the same cycle SHALL still be accepted.
REQ-033 No grant SHALL be accepted when vrf_req_o=0; a vrf_gnt_i without a request SHALL be ignored.

Reset
REQ-034 Asserting rst_ni low SHALL immediately force IDLE, credits=BufferDepth, remaining=0, address=0, and credit_err_o=0.
REQ-035 During reset, req_ready_o SHALL be 1 and vrf_req_o, operand_issued_o, queue_cmd_valid_o and busy_o SHALL be 0.
REQ-036 Reset mid-command SHALL abandon the command, with no further request or strobe.

Verification
REQ-037 The bench SHALL cover this case: BufferDepth=2, addr=0x010, len=3, gnt tied 1, no consume -> strobe len=3; grants at 0x010 and 0x011; stall with credits=0; after one consume, a grant at 0x012; then IDLE.
REQ-038 The bench SHALL cover this case: addr=0x3FF (AddrWidth=10), len=2, full credits -> addresses 0x3FF then 0x000.
REQ-039 The bench SHALL cover this case: len=0 handshake -> no strobe, no vrf_req_o, req_ready_o stays 1.
REQ-040 The bench SHALL cover this case: credits=1 with grant and consume in the same cycle -> credits stay 1 and issue continues every cycle.
REQ-041 The bench SHALL cover this case: kill_i after 2 of 5 words -> IDLE next cycle, credits=BufferDepth-2, a new request accepted.
REQ-042 The bench SHALL cover this case: consume while credits=BufferDepth -> credits stay BufferDepth and credit_err_o=1 until rst_ni is asserted.

Source files
------------

// File: rtl/operand_fetch_sequencer.sv
// Purpose: walks a VRF word range for one fetch command, issuing reads only while the operand queue has credit.
// Latency: command strobe and first read request one cycle after acceptance; one grant per cycle at best.
// Backpressure: req_ready_o low while a command is in flight; reads stall at zero credits or no grant.
module operand_fetch_sequencer #(
    parameter int BufferDepth = 2,
    parameter int AddrWidth   = 10,
    parameter int LenWidth    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]  req_len_i,
    input  logic [3:0]           req_conv_i,
    input  logic                 kill_i,
    output logic                 vrf_req_o,
    output logic [AddrWidth-1:0] vrf_addr_o,
    input  logic                 vrf_gnt_i,
    output logic                 operand_issued_o,
    input  logic                 operand_consumed_i,
    output logic                 queue_cmd_valid_o,
    output logic [3:0]           queue_cmd_conv_o,
    output logic [LenWidth-1:0]  queue_cmd_len_o,
    output logic                 busy_o,
    output logic                 credit_err_o
);

    localparam int CredWidth = $clog2(BufferDepth + 1);
    localparam logic [CredWidth-1:0] CredMax = CredWidth'(BufferDepth);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q;
    logic [LenWidth-1:0]    remaining_q;
    logic [LenWidth-1:0]    len_q;
    logic [3:0]             conv_q;
    logic [CredWidth-1:0]   credits_q;
    logic                   cmd_pend_q;
    logic                   credit_err_q;

    logic                   accept;
    logic                   grant;
    logic                   last_word;

    // A zero-length command is handshaken but otherwise dropped.
    assign accept    = req_valid_i && req_ready_o && (req_len_i != '0);
    assign grant     = vrf_req_o && vrf_gnt_i;
    assign last_word = (remaining_q == LenWidth'(1));

    assign req_ready_o       = (state_q == IDLE);
    assign busy_o            = (state_q != IDLE);
    assign vrf_req_o         = (state_q == ISSUE) && (credits_q != '0) &&
                               (remaining_q != '0) && !kill_i;
    assign vrf_addr_o        = addr_q;
    assign operand_issued_o  = grant;
    assign queue_cmd_valid_o = cmd_pend_q;
    assign queue_cmd_conv_o  = conv_q;
    assign queue_cmd_len_o   = len_q;
    assign credit_err_o      = credit_err_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enter ISSUE on a non-empty command, leave on kill or final grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else if (grant && last_word) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command registers: latch on accept, advance per grant, drop remainder on kill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            remaining_q <= '0;
            len_q       <= '0;
            conv_q      <= '0;
            cmd_pend_q  <= 1'b0;
        end else begin
            cmd_pend_q <= accept;
            if (accept) begin
                addr_q      <= req_addr_i;
                remaining_q <= req_len_i;
                len_q       <= req_len_i;
                conv_q      <= req_conv_i;
            end else if ((state_q == ISSUE) && kill_i) begin
                remaining_q <= '0;
            end else if (grant) begin
                addr_q      <= addr_q + AddrWidth'(1);
                remaining_q <= remaining_q - LenWidth'(1);
            end
        end
    end

    // Credits: one spent per grant, one returned per consume; overflow saturates and sets a sticky error.
    // Credits are never restored on kill because words already granted still drain through the queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits_q    <= CredMax;
            credit_err_q <= 1'b0;
        end else begin
            case ({grant, operand_consumed_i})
                2'b10: credits_q <= credits_q - CredWidth'(1);
                2'b01: begin
                    if (credits_q == CredMax) begin
                        credit_err_q <= 1'b1;
                    end else begin
                        credits_q <= credits_q + CredWidth'(1);
                    end
                end
                default: credits_q <= credits_q;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Purpose: directed stimulus for operand_fetch_sequencer with a queue-based reference model.
// Latency: model is compared on every falling edge; inputs change 1 time unit after rising edges.
// Backpressure: grant and consume are driven explicitly by each directed scenario.
module tb_operand_fetch_sequencer;

    localparam int BD = 2;
    localparam int AW = 10;
    localparam int LW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic [LW-1:0] req_len_i;
    logic [3:0]    req_conv_i;
    logic          kill_i;
    logic          vrf_req_o;
    logic [AW-1:0] vrf_addr_o;
    logic          vrf_gnt_i;
    logic          operand_issued_o;
    logic          operand_consumed_i;
    logic          queue_cmd_valid_o;
    logic [3:0]    queue_cmd_conv_o;
    logic [LW-1:0] queue_cmd_len_o;
    logic          busy_o;
    logic          credit_err_o;

    int checks = 0;
    int errors = 0;

    operand_fetch_sequencer #(
        .BufferDepth(BD),
        .AddrWidth  (AW),
        .LenWidth   (LW)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_addr_i        (req_addr_i),
        .req_len_i         (req_len_i),
        .req_conv_i        (req_conv_i),
        .kill_i            (kill_i),
        .vrf_req_o         (vrf_req_o),
        .vrf_addr_o        (vrf_addr_o),
        .vrf_gnt_i         (vrf_gnt_i),
        .operand_issued_o  (operand_issued_o),
        .operand_consumed_i(operand_consumed_i),
        .queue_cmd_valid_o (queue_cmd_valid_o),
        .queue_cmd_conv_o  (queue_cmd_conv_o),
        .queue_cmd_len_o   (queue_cmd_len_o),
        .busy_o            (busy_o),
        .credit_err_o      (credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a command is a list of word addresses still to be granted.
    bit m_busy;
    int m_cred;
    bit m_err;
    bit m_strobe;
    int m_slen;
    int m_sconv;
    int m_words[$];
    int g_log[$];
    bit exp_req;
    bit exp_gnt;
    bit was_busy;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            m_busy   = 1'b0;
            m_cred   = BD;
            m_err    = 1'b0;
            m_strobe = 1'b0;
            m_words.delete();
            chk("rst_ready", int'(req_ready_o), 1);
            chk("rst_vrf_req", int'(vrf_req_o), 0);
            chk("rst_issued", int'(operand_issued_o), 0);
            chk("rst_strobe", int'(queue_cmd_valid_o), 0);
            chk("rst_busy", int'(busy_o), 0);
            chk("rst_err", int'(credit_err_o), 0);
        end else begin
            exp_req = m_busy && (m_cred > 0) && (m_words.size() > 0) && !kill_i;
            exp_gnt = exp_req && vrf_gnt_i;
            chk("req_ready", int'(req_ready_o), int'(!m_busy));
            chk("busy", int'(busy_o), int'(m_busy));
            chk("vrf_req", int'(vrf_req_o), int'(exp_req));
            if (exp_req) chk("vrf_addr", int'(vrf_addr_o), m_words[0]);
            chk("issued", int'(operand_issued_o), int'(exp_gnt));
            chk("strobe", int'(queue_cmd_valid_o), int'(m_strobe));
            if (m_strobe) begin
                chk("strobe_len", int'(queue_cmd_len_o), m_slen);
                chk("strobe_conv", int'(queue_cmd_conv_o), m_sconv);
            end
            chk("credit_err", int'(credit_err_o), int'(m_err));
            if (operand_issued_o) g_log.push_back(int'(vrf_addr_o));

            // Advance the model to the state after the coming rising edge.
            was_busy = m_busy;
            if (exp_gnt) begin
                void'(m_words.pop_front());
                if (!operand_consumed_i) m_cred--;
            end else if (operand_consumed_i) begin
                if (m_cred == BD) m_err = 1'b1;
                else m_cred++;
            end
            m_strobe = 1'b0;
            if (was_busy && kill_i) begin
                m_words.delete();
                m_busy = 1'b0;
            end else if (exp_gnt && m_words.size() == 0) begin
                m_busy = 1'b0;
            end
            if (!was_busy && req_valid_i && req_len_i != 0) begin
                m_busy   = 1'b1;
                m_strobe = 1'b1;
                m_slen   = int'(req_len_i);
                m_sconv  = int'(req_conv_i);
                for (int i = 0; i < int'(req_len_i); i++)
                    m_words.push_back((int'(req_addr_i) + i) % (1 << AW));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send(input int addr, input int len, input int conv);
        req_valid_i = 1'b1;
        req_addr_i  = AW'(addr);
        req_len_i   = LW'(len);
        req_conv_i  = 4'(conv);
        step(1);
        req_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni             = 1'b0;
        req_valid_i        = 1'b0;
        req_addr_i         = '0;
        req_len_i          = '0;
        req_conv_i         = '0;
        kill_i             = 1'b0;
        vrf_gnt_i          = 1'b0;
        operand_consumed_i = 1'b0;
        step(2);
        rst_ni = 1'b1;
        step(1);

        // Three words at 0x010 with two credits: stall until one credit returns.
        vrf_gnt_i = 1'b1;
        g_log.delete();
        send('h010, 3, 5);
        step(4);
        chk("s1_cred_stall", m_cred, 0);
        chk("s1_stall_req", int'(vrf_req_o), 0);
        operand_consumed_i = 1'b1;
        step(1);
        operand_consumed_i = 1'b0;
        step(3);
        chk("s1_grants", g_log.size(), 3);
        if (g_log.size() == 3) begin
            chk("s1_addr0", g_log[0], 'h010);
            chk("s1_addr1", g_log[1], 'h011);
            chk("s1_addr2", g_log[2], 'h012);
        end
        chk("s1_idle", int'(busy_o), 0);
        operand_consumed_i = 1'b1;
        step(2);
        operand_consumed_i = 1'b0;
        chk("s1_cred_back", m_cred, 2);

        // Address wrap at the top of the VRF.
        g_log.delete();
        send('h3FF, 2, 9);
        step(3);
        chk("s2_grants", g_log.size(), 2);
        if (g_log.size() == 2) begin
            chk("s2_addr0", g_log[0], 'h3FF);
            chk("s2_addr1", g_log[1], 'h000);
        end
        operand_consumed_i = 1'b1;
        step(2);
        operand_consumed_i = 1'b0;

        // Zero-length command is swallowed.
        send('h055, 0, 3);
        chk("s3_ready", int'(req_ready_o), 1);
        chk("s3_strobe", int'(queue_cmd_valid_o), 0);
        step(2);

        // Credits held at 1 by simultaneous grant and consume.
        g_log.delete();
        send('h020, 6, 2);
        step(1);
        operand_consumed_i = 1'b1;
        step(5);
        operand_consumed_i = 1'b0;
        step(2);
        chk("s4_grants", g_log.size(), 6);
        chk("s4_cred", m_cred, 1);
        operand_consumed_i = 1'b1;
        step(1);
        operand_consumed_i = 1'b0;

        // Kill after two of five words; a new command is accepted despite kill in IDLE.
        g_log.delete();
        send('h100, 5, 7);
        step(2);
        kill_i = 1'b1;
        step(1);
        chk("s5_idle", int'(busy_o), 0);
        chk("s5_ready", int'(req_ready_o), 1);
        chk("s5_cred", m_cred, BD - 2);
        send('h200, 1, 4);
        kill_i = 1'b0;
        step(1);
        chk("s5_new_busy", int'(busy_o), 1);
        chk("s5_no_credit", int'(vrf_req_o), 0);
        operand_consumed_i = 1'b1;
        step(1);
        operand_consumed_i = 1'b0;
        step(2);
        chk("s5_grants", g_log.size(), 3);
        if (g_log.size() == 3) chk("s5_last_addr", g_log[2], 'h200);
        operand_consumed_i = 1'b1;
        step(2);
        operand_consumed_i = 1'b0;

        // Reset in the middle of a command.
        send('h300, 4, 1);
        step(1);
        rst_ni = 1'b0;
        step(2);
        rst_ni = 1'b1;
        step(3);
        chk("s7_idle", int'(busy_o), 0);

        // Credit overflow is sticky until reset.
        operand_consumed_i = 1'b1;
        step(1);
        operand_consumed_i = 1'b0;
        step(1);
        chk("s6_err", int'(credit_err_o), 1);
        step(3);
        chk("s6_err_sticky", int'(credit_err_o), 1);
        rst_ni = 1'b0;
        #1;
        chk("s6_err_cleared", int'(credit_err_o), 0);
        step(2);
        rst_ni = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
